serial_tx_ctrl: RTL and testbench

Frame sequencer for the board's serial transmit path. Accepts one parallel byte through a ready/load handshake and shifts it out on a single line as start bit, DATA_BITS data bits (LSB first) and one stop bit. Each bit is held for CLKS_PER_BIT clock cycles. Internally it sequences a bit-slot counter (sample tick) and a bit-index counter, the same count-and-clear counter style used elsewhere in the lab datapath.

---
 rtl/serial_pkg.sv | 13 +
 rtl/bit_slot_counter.sv | 25 ++
 rtl/serial_tx_ctrl.sv | 105 ++++++++++
 tb/tb_serial_tx_ctrl.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// Shared types and constants for the serial transmit path.
package serial_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam logic TX_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/bit_slot_counter.sv
// Count-and-clear up-counter with a terminal flag; clear wins over enable.
module bit_slot_counter #(
    parameter int WIDTH = 4,
    parameter int TERM  = 15
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] count,
    output logic             term
);

    localparam logic [WIDTH-1:0] TERM_V = WIDTH'(TERM);

    always_ff @(posedge clk) begin
        if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + WIDTH'(1);
        end
    end

    assign term = (count == TERM_V);

endmodule

// File: rtl/serial_tx_ctrl.sv
// Serial frame sequencer: start bit, DATA_BITS data bits LSB first, one stop bit,
// each held CLKS_PER_BIT cycles on a registered tx line.
module serial_tx_ctrl
    import serial_pkg::*;
#(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic [DATA_BITS-1:0] data_in,
    output logic                 ready,
    output logic                 busy,
    output logic                 tx,
    output logic                 done
);

    localparam int SLOT_W = ($clog2(CLKS_PER_BIT) > 0) ? $clog2(CLKS_PER_BIT) : 1;

    tx_state_t              state, state_n;
    logic [DATA_BITS-1:0]   shift_reg, shift_n;
    logic                   tx_n, done_n;
    logic [SLOT_W-1:0]      slot;
    logic                   slot_end;
    logic [3:0]             idx;
    logic                   idx_last;
    logic                   count_unused;

    // Handshake: a frame starts on any edge where load=1 and ready=1;
    // ready is high exactly while idle, and load is ignored otherwise.
    assign ready = (state == IDLE);
    assign busy  = ~ready;

    // Slot restarts on every state entry and every bit boundary.
    bit_slot_counter #(.WIDTH(SLOT_W), .TERM(CLKS_PER_BIT - 1)) u_slot (
        .clk   (clk),
        .clr   (rst | (state == IDLE) | slot_end),
        .en    (state != IDLE),
        .count (slot),
        .term  (slot_end)
    );

    bit_slot_counter #(.WIDTH(4), .TERM(DATA_BITS - 1)) u_index (
        .clk   (clk),
        .clr   (rst | (state == IDLE)),
        .en    ((state == DATA) & slot_end & ~idx_last),
        .count (idx),
        .term  (idx_last)
    );

    assign count_unused = ^{slot, idx};

    always_comb begin
        state_n = state;
        shift_n = shift_reg;
        done_n  = 1'b0;
        tx_n    = TX_IDLE_LEVEL;
        case (state)
            IDLE: begin
                if (load) begin
                    state_n = START;
                    shift_n = data_in;
                end
            end
            START: begin
                if (slot_end) state_n = DATA;
            end
            DATA: begin
                if (slot_end) begin
                    if (idx_last) state_n = STOP;
                    else          shift_n = shift_reg >> 1;
                end
            end
            STOP: begin
                if (slot_end) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
        // tx is registered from the next state so it lines up with the state it belongs to.
        case (state_n)
            START:   tx_n = 1'b0;
            DATA:    tx_n = shift_n[0];
            default: tx_n = TX_IDLE_LEVEL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            shift_reg <= '0;
            tx        <= TX_IDLE_LEVEL;
            done      <= 1'b0;
        end else begin
            state     <= state_n;
            shift_reg <= shift_n;
            tx        <= tx_n;
            done      <= done_n;
        end
    end

endmodule

// File: tb/tb_serial_tx_ctrl.sv
// Directed bench for serial_tx_ctrl: 8-bit/4-clock instance plus a 5-bit/2-clock instance.
module tb_serial_tx_ctrl;

    logic       clk;
    logic       rst;
    logic       load;
    logic [7:0] data_in;
    logic       ready, busy, tx, done;

    logic       load_b;
    logic [4:0] data_b;
    logic       ready_b, busy_b, tx_b, done_b;

    int n_assert;
    int n_fail;

    serial_tx_ctrl #(.DATA_BITS(8), .CLKS_PER_BIT(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .data_in (data_in),
        .ready   (ready),
        .busy    (busy),
        .tx      (tx),
        .done    (done)
    );

    serial_tx_ctrl #(.DATA_BITS(5), .CLKS_PER_BIT(2)) dut_b (
        .clk     (clk),
        .rst     (rst),
        .load    (load_b),
        .data_in (data_b),
        .ready   (ready_b),
        .busy    (busy_b),
        .tx      (tx_b),
        .done    (done_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string name, input logic exp_done);
        n_assert++;
        if ({tx, ready, busy, done} !== {1'b1, 1'b1, 1'b0, exp_done}) begin
            n_fail++;
            $display("FAIL %s: tx/ready/busy/done = %b%b%b%b, required %b%b%b%b",
                     name, tx, ready, busy, done, 1'b1, 1'b1, 1'b0, exp_done);
        end
    endtask

    // Expected frame levels, index 0 first: start, data LSB first, stop.
    function automatic logic [9:0] frame_bits(input logic [7:0] d);
        return {1'b1, d, 1'b0};
    endfunction

    task automatic start_frame(input logic [7:0] d, input string name);
        n_assert++;
        if (ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_ready_before_load: ready=%b, required 1", name, ready);
        end
        load    = 1'b1;
        data_in = d;
        tick();
        load    = 1'b0;
    endtask

    // Called in cycle k+1; returns in the done cycle k+41. Optionally pulses a
    // stray load at frame cycle stray_at (negative = none).
    task automatic check_frame(input logic [9:0] bits, input string name, input int stray_at);
        int busy_cnt;
        busy_cnt = 0;
        for (int c = 0; c < 40; c++) begin
            n_assert++;
            if (tx !== bits[c/4] || done !== 1'b0 || ready !== 1'b0) begin
                n_fail++;
                $display("FAIL %s_cycle%0d: tx=%b done=%b ready=%b, required tx=%b done=0 ready=0",
                         name, c, tx, done, ready, bits[c/4]);
            end
            if (busy === 1'b1) busy_cnt++;
            if (c == stray_at) begin
                load    = 1'b1;
                data_in = 8'hFF;
            end else begin
                load    = 1'b0;
            end
            tick();
        end
        load = 1'b0;
        n_assert++;
        if (busy_cnt != 40) begin
            n_fail++;
            $display("FAIL %s_busy_len: busy cycles=%0d, required 40", name, busy_cnt);
        end
        check_idle({name, "_done_cycle"}, 1'b1);
    endtask

    task automatic test_reset();
        rst     = 1'b1;
        load    = 1'b1;
        data_in = 8'hFF;
        load_b  = 1'b1;
        data_b  = 5'h1F;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_idle("reset_hold", 1'b0);
            n_assert++;
            if ({tx_b, ready_b, busy_b, done_b} !== 4'b1100) begin
                n_fail++;
                $display("FAIL reset_hold_b: tx/ready/busy/done=%b%b%b%b, required 1100",
                         tx_b, ready_b, busy_b, done_b);
            end
        end
        rst    = 1'b0;
        load   = 1'b0;
        load_b = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_idle("reset_release_no_frame", 1'b0);
        end
    endtask

    task automatic test_single_frame();
        start_frame(8'hA5, "single");
        check_frame(10'b11_0100_1010, "single_a5", -1);
        tick();
        check_idle("single_after_done", 1'b0);
    endtask

    task automatic test_back_to_back();
        start_frame(8'h00, "b2b_first");
        check_frame(frame_bits(8'h00), "b2b_00", -1);
        load    = 1'b1;
        data_in = 8'hFF;
        tick();
        load    = 1'b0;
        check_frame(frame_bits(8'hFF), "b2b_ff", -1);
        tick();
        check_idle("b2b_after_done", 1'b0);
    endtask

    task automatic test_load_while_busy();
        int done_cnt;
        start_frame(8'h3C, "busy_load");
        check_frame(frame_bits(8'h3C), "busy_load_3c", 9);
        done_cnt = 1;
        for (int i = 0; i < 45; i++) begin
            tick();
            if (done === 1'b1) done_cnt++;
            n_assert++;
            if (tx !== 1'b1 || ready !== 1'b1) begin
                n_fail++;
                $display("FAIL busy_load_trailing%0d: tx=%b ready=%b, required 1 1", i, tx, ready);
            end
        end
        n_assert++;
        if (done_cnt != 1) begin
            n_fail++;
            $display("FAIL busy_load_done_count: done pulses=%0d, required 1", done_cnt);
        end
    endtask

    task automatic test_reset_mid_frame();
        start_frame(8'h81, "midrst");
        for (int c = 0; c < 16; c++) tick();
        n_assert++;
        if (tx !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_in_data: tx=%b busy=%b, required 0 1", tx, busy);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_idle("midrst_next_cycle", 1'b0);
        for (int i = 0; i < 45; i++) begin
            tick();
            check_idle("midrst_no_done", 1'b0);
        end
        start_frame(8'h81, "midrst_reload");
        check_frame(10'b11_0000_0010, "midrst_81", -1);
        tick();
        check_idle("midrst_after_done", 1'b0);
    endtask

    task automatic test_param_sweep();
        logic [6:0] bits;
        bits = 7'b110_1010;
        n_assert++;
        if (ready_b !== 1'b1) begin
            n_fail++;
            $display("FAIL sweep_ready: ready=%b, required 1", ready_b);
        end
        load_b = 1'b1;
        data_b = 5'h15;
        tick();
        load_b = 1'b0;
        for (int c = 0; c < 14; c++) begin
            n_assert++;
            if (tx_b !== bits[c/2] || busy_b !== 1'b1 || done_b !== 1'b0) begin
                n_fail++;
                $display("FAIL sweep_cycle%0d: tx=%b busy=%b done=%b, required tx=%b busy=1 done=0",
                         c, tx_b, busy_b, done_b, bits[c/2]);
            end
            tick();
        end
        n_assert++;
        if ({tx_b, ready_b, busy_b, done_b} !== 4'b1101) begin
            n_fail++;
            $display("FAIL sweep_done: tx/ready/busy/done=%b%b%b%b, required 1101",
                     tx_b, ready_b, busy_b, done_b);
        end
        tick();
        n_assert++;
        if (done_b !== 1'b0) begin
            n_fail++;
            $display("FAIL sweep_done_width: done=%b, required 0", done_b);
        end
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        rst      = 1'b1;
        load     = 1'b0;
        data_in  = 8'h00;
        load_b   = 1'b0;
        data_b   = 5'h00;
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_load_while_busy();
        test_reset_mid_frame();
        test_param_sweep();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
